// File: rtl/inc_arbiter.sv
// -----------------------------------------------------------------------------
// inc_arbiter
//
// Purpose:
//   Shares one 16-bit incrementer between NUM_REQ requesters (program
//   counters, stack/pointer registers, DMA address counters). A round-robin
//   arbiter picks one requester at a time with a req/gnt handshake. The
//   winner's operand is registered, incremented on the next edge, and
//   presented on a valid/ready result port.
//
//   Only one operation is in flight at a time. The best case is one result
//   every two cycles: arbitrate, execute, then arbitrate again on the same
//   edge that the result is accepted.
//
// Optional feature (macro INC_ARB_DEC_EN):
//   When the macro is defined, the port req_dec is added. It is sampled
//   together with the winner's operand. A set bit turns that requester's
//   operation into a decrement. out_carry then reports the borrow, which is
//   set only when the operand was 0x0000. Stack-pointer pops use this.
//   When the macro is undefined, every operation is an increment.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   req        in   [NUM_REQ]    per-requester request, held until gnt
//   in_data    in   [NUM_REQ*16] packed operands, requester i at [16*i +: 16]
//   req_dec    in   [NUM_REQ]    per-requester decrement select (INC_ARB_DEC_EN)
//   gnt        out  [NUM_REQ]    registered one-hot grant pulse
//   out_valid  out  1            result valid
//   out_ready  in   1            consumer accepts the result
//   out_data   out  16           operand +1 (or -1) modulo 2^16
//   out_carry  out  1            carry (or borrow) out of bit 15
//   out_id     out  [ID_W]       index of the requester that owns out_data
// -----------------------------------------------------------------------------
module inc_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*16-1:0]  in_data,
`ifdef INC_ARB_DEC_EN
    input  logic [NUM_REQ-1:0]     req_dec,
`endif
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_data,
    output logic                   out_carry,
    output logic [ID_W-1:0]        out_id
);

    // One extra bit lets the wrap-around sum rr_ptr + offset be formed
    // without overflow before it is reduced modulo NUM_REQ.
    localparam int SW = ID_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;

    logic [ID_W-1:0]      rr_ptr_r;
    logic [15:0]          op_r;
    logic [ID_W-1:0]      id_r;
`ifdef INC_ARB_DEC_EN
    logic                 dec_r;
`endif

    logic [NUM_REQ-1:0]   gnt_r;
    logic                 out_valid_r;
    logic [15:0]          out_data_r;
    logic                 out_carry_r;
    logic [ID_W-1:0]      out_id_r;

    logic                 any_req_s;
    logic                 arb_s;
    logic [ID_W-1:0]      win_s;
    logic [SW-1:0]        cand_s;
    logic [15:0]          win_op_s;
    logic [16:0]          res_s;

    logic [NUM_REQ-1:0]   gnt_nxt_s;
    logic                 out_valid_nxt_s;
    logic [15:0]          out_data_nxt_s;
    logic                 out_carry_nxt_s;
    logic [ID_W-1:0]      out_id_nxt_s;

    assign gnt       = gnt_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_carry = out_carry_r;
    assign out_id    = out_id_r;

    // Round-robin winner search from rr_ptr+1 with wrap-around.
    // The loop walks from the farthest offset to the nearest one, so the
    // last matching assignment is the nearest asserted requester.
    always_comb begin
        win_s  = rr_ptr_r;
        cand_s = {SW{1'b0}};
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_s = {1'b0, rr_ptr_r} + SW'(k);
            if (cand_s >= SW'(NUM_REQ)) begin
                cand_s = cand_s - SW'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (req[cand_s[ID_W-1:0]]) begin
                win_s = cand_s[ID_W-1:0];
            end else begin
                win_s = win_s;
            end
        end
    end

    // Decide whether this edge is an arbitration edge.
    // Arbitration happens from IDLE, or from OUT on the edge that hands the
    // result to the consumer.
    always_comb begin
        any_req_s = |req;
        arb_s     = 1'b0;
        case (state_r)
            ST_IDLE: arb_s = any_req_s;
            ST_OUT:  arb_s = any_req_s & out_ready;
            ST_EXEC: arb_s = 1'b0;
            default: arb_s = 1'b0;
        endcase
    end

    // Operand mux. Only the winner's slice is ever captured.
    always_comb begin
        win_op_s = in_data[{win_s, 4'b0000} +: 16];
    end

    // Shared incrementer. Bit 16 is the carry (increment) or borrow (decrement).
    always_comb begin
`ifdef INC_ARB_DEC_EN
        if (dec_r) begin
            res_s = {1'b0, op_r} - 17'd1;
        end else begin
            res_s = {1'b0, op_r} + 17'd1;
        end
`else
        res_s = {1'b0, op_r} + 17'd1;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt_s = ST_OUT;
            end
            ST_OUT: begin
                if (!out_ready) begin
                    state_nxt_s = ST_OUT;
                end else if (arb_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values for the registered result port and grant.
    // The result fields keep their last value unless a new result is loaded.
    always_comb begin
        out_valid_nxt_s = out_valid_r;
        out_data_nxt_s  = out_data_r;
        out_carry_nxt_s = out_carry_r;
        out_id_nxt_s    = out_id_r;
        if (arb_s) begin
            gnt_nxt_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
        end else begin
            gnt_nxt_s = {NUM_REQ{1'b0}};
        end
        case (state_r)
            ST_IDLE: begin
                out_valid_nxt_s = 1'b0;
            end
            ST_EXEC: begin
                out_valid_nxt_s = 1'b1;
                out_data_nxt_s  = res_s[15:0];
                out_carry_nxt_s = res_s[16];
                out_id_nxt_s    = id_r;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_nxt_s = 1'b0;
                end else begin
                    out_valid_nxt_s = 1'b1;
                end
            end
            default: begin
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered outputs. A reset clears them asynchronously and drops any
    // grant, result or operand that is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_r       <= {NUM_REQ{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= 16'h0000;
            out_carry_r <= 1'b0;
            out_id_r    <= {ID_W{1'b0}};
        end else begin
            gnt_r       <= gnt_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_carry_r <= out_carry_nxt_s;
            out_id_r    <= out_id_nxt_s;
        end
    end

    // Operand capture and round-robin pointer update on arbitration edges.
    // The pointer resets to NUM_REQ-1, which gives requester 0 first priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= ID_W'(NUM_REQ - 1);
            op_r     <= 16'h0000;
            id_r     <= {ID_W{1'b0}};
`ifdef INC_ARB_DEC_EN
            dec_r    <= 1'b0;
`endif
        end else if (arb_s) begin
            rr_ptr_r <= win_s;
            op_r     <= win_op_s;
            id_r     <= win_s;
`ifdef INC_ARB_DEC_EN
            dec_r    <= req_dec[win_s];
`endif
        end else begin
            rr_ptr_r <= rr_ptr_r;
            op_r     <= op_r;
            id_r     <= id_r;
`ifdef INC_ARB_DEC_EN
            dec_r    <= dec_r;
`endif
        end
    end

endmodule

// File: tb/tb_inc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_inc_arbiter
//
// Directed testbench for inc_arbiter with NUM_REQ = 4.
//
// A transaction-level model predicts the arbiter's behaviour:
//   - the winner is found with modular arithmetic,
//   - the result is computed with integer arithmetic.
// A compare process checks gnt and out_valid against the model on every
// falling edge. While out_valid is high it also checks out_data, out_carry
// and out_id.
//
// The directed sequences also check DUT outputs, and a few model outputs,
// against hand-computed literal values.
//
// Define INC_ARB_DEC_EN to also exercise the decrement feature.
// -----------------------------------------------------------------------------
module tb_inc_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NUM_REQ-1:0]    req = '0;
    logic [NUM_REQ*16-1:0] in_data = '0;
`ifdef INC_ARB_DEC_EN
    logic [NUM_REQ-1:0]    req_dec = '0;
`endif
    logic [NUM_REQ-1:0]    gnt;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [15:0]           out_data;
    logic                  out_carry;
    logic [ID_W-1:0]       out_id;

    int n_vec = 0;
    int n_err = 0;

    inc_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in_data   (in_data),
`ifdef INC_ARB_DEC_EN
        .req_dec   (req_dec),
`endif
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_phase: 0 = nothing in flight, 1 = operand captured, 2 = result waiting
    int               m_phase;
    int               m_ptr;
    int               m_owner;
    logic [15:0]      m_op;
    logic             m_dec;
    logic [NUM_REQ-1:0] m_gnt;
    logic             m_valid;
    logic [15:0]      m_data;
    logic             m_carry;
    int               m_id;
    int               m_win;
    logic             m_arb;
    int               m_res;

    function automatic int pick(input int ptr, input logic [NUM_REQ-1:0] r);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    always_comb begin
        m_win = pick(m_ptr, req);
        m_arb = (m_win >= 0) && ((m_phase == 0) || (m_phase == 2 && out_ready));
        m_res = m_dec ? (int'(m_op) - 1) : (int'(m_op) + 1);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0;
            m_ptr   <= NUM_REQ - 1;
            m_owner <= 0;
            m_op    <= 16'h0000;
            m_dec   <= 1'b0;
            m_gnt   <= '0;
            m_valid <= 1'b0;
            m_data  <= 16'h0000;
            m_carry <= 1'b0;
            m_id    <= 0;
        end else begin
            m_gnt <= '0;
            if (m_arb) begin
                m_gnt[m_win] <= 1'b1;
                m_op    <= in_data[16*m_win +: 16];
`ifdef INC_ARB_DEC_EN
                m_dec   <= req_dec[m_win];
`endif
                m_owner <= m_win;
                m_ptr   <= m_win;
                m_phase <= 1;
                m_valid <= 1'b0;
            end else if (m_phase == 1) begin
                m_phase <= 2;
                m_valid <= 1'b1;
                m_data  <= 16'(m_res);
                m_carry <= (m_res < 0) || (m_res > 65535);
                m_id    <= m_owner;
            end else if (m_phase == 2 && out_ready) begin
                m_phase <= 0;
                m_valid <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("model_gnt", 32'(gnt), 32'(m_gnt));
            check("model_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check("model_data", 32'(out_data), 32'(m_data));
                check("model_carry", 32'(out_carry), 32'(m_carry));
                check("model_id", 32'(out_id), 32'(m_id));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'h0);
        check({tag, "_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_data"}, 32'(out_data), 32'h0);
        check({tag, "_carry"}, 32'(out_carry), 32'h0);
        check({tag, "_id"}, 32'(out_id), 32'h0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        #2 reset = 1'b1;
        #1 check_zero_outputs("reset");
        tick(); tick();
        reset = 1'b0;
        tick();
        check("idle_gnt", 32'(gnt), 32'h0);

        // Test 1: single request from requester 0.
        in_data[15:0] = 16'h0041;
        req = 4'b0001;
        tick();
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_valid_lat", 32'(out_valid), 32'h0);
        req = 4'b0000;
        tick();
        check("t1_gnt_pulse", 32'(gnt), 32'h0);
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_data", 32'(out_data), 32'h0042);
        check("t1_carry", 32'(out_carry), 32'h0);
        check("t1_id", 32'(out_id), 32'h0);
        check("t1_model_data", 32'(m_data), 32'h0042);
        tick();
        check("t1_hold_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        tick();
        check("t1_accept", 32'(out_valid), 32'h0);
        check("t1_retain", 32'(out_data), 32'h0042);

        // Test 2: requester 2 with operand 0xFFFF wraps to 0x0000 with carry.
        in_data[47:32] = 16'hFFFF;
        req = 4'b0100;
        tick();
        check("t2_gnt", 32'(gnt), 32'h4);
        req = 4'b0000;
        tick();
        check("t2_data", 32'(out_data), 32'h0000);
        check("t2_carry", 32'(out_carry), 32'h1);
        check("t2_id", 32'(out_id), 32'h2);
        check("t2_model_carry", 32'(m_carry), 32'h1);
        tick();

        // Test 3: all four requesters held high, back-to-back service.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        in_data = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        req = 4'b1111;
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (t % 2 == 1) begin
                check("t3_gnt", 32'(gnt), 32'(1) << (((t - 1) / 2) % 4));
                check("t3_novalid", 32'(out_valid), 32'h0);
            end else begin
                check("t3_gnt_zero", 32'(gnt), 32'h0);
                check("t3_valid", 32'(out_valid), 32'h1);
                check("t3_data", 32'(out_data), 32'h0011 + 32'h0010 * 32'(t / 2 - 1));
                check("t3_id", 32'(out_id), 32'(t / 2 - 1));
            end
            if (t == 9) req = 4'b0000;
        end
        tick();
        check("t3_last_data", 32'(out_data), 32'h0011);
        check("t3_last_id", 32'(out_id), 32'h0);
        tick();
        check("t3_idle", 32'(out_valid), 32'h0);

        // Test 4: backpressure while requester 1 waits.
        out_ready = 1'b0;
        in_data[63:48] = 16'h1234;
        in_data[31:16] = 16'h0100;
        req = 4'b1000;
        tick();
        check("t4_gnt3", 32'(gnt), 32'h8);
        req = 4'b0010;
        tick();
        check("t4_data", 32'(out_data), 32'h1235);
        check("t4_id", 32'(out_id), 32'h3);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t4_stall_data", 32'(out_data), 32'h1235);
            check("t4_stall_valid", 32'(out_valid), 32'h1);
            check("t4_stall_gnt", 32'(gnt), 32'h0);
        end
        out_ready = 1'b1;
        tick();
        check("t4_gnt1", 32'(gnt), 32'h2);
        check("t4_drop_valid", 32'(out_valid), 32'h0);
        req = 4'b0000;
        tick();
        check("t4_data1", 32'(out_data), 32'h0101);
        check("t4_id1", 32'(out_id), 32'h1);
        tick();

        // Test 5: reset pulse while an operation is in EXEC.
        in_data[47:32] = 16'h7777;
        req = 4'b0100;
        tick();
        check("t5_gnt", 32'(gnt), 32'h4);
        reset = 1'b1;
        #1 check_zero_outputs("t5_async");
        req = 4'b0000;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("t5_no_gnt", 32'(gnt), 32'h0);
        check("t5_no_valid", 32'(out_valid), 32'h0);
        in_data[15:0] = 16'h0005;
        req = 4'b1001;
        tick();
        check("t5_prio0", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        check("t5_data", 32'(out_data), 32'h0006);
        check("t5_id", 32'(out_id), 32'h0);
        tick();

`ifdef INC_ARB_DEC_EN
        // Test 6: decrement on requester 3.
        req_dec = 4'b1000;
        in_data[63:48] = 16'h0000;
        req = 4'b1000;
        tick();
        check("t6_gnt", 32'(gnt), 32'h8);
        req = 4'b0000;
        tick();
        check("t6_data", 32'(out_data), 32'hFFFF);
        check("t6_borrow", 32'(out_carry), 32'h1);
        check("t6_model_data", 32'(m_data), 32'hFFFF);
        tick();
        in_data[63:48] = 16'h0100;
        req = 4'b1000;
        tick();
        req = 4'b0000;
        tick();
        check("t6_data2", 32'(out_data), 32'h00FF);
        check("t6_borrow2", 32'(out_carry), 32'h0);
        tick();
        req_dec = 4'b0000;
`endif

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
